// File: rtl/spi_flash_reader.sv
// SPI flash read sequencer: issues READ (0x03) or FAST_READ (0x0B, macro SPI_FLASH_READER_FAST_READ_EN)
// through a byte-level SPI master and buffers returned data bytes in a first-word-fall-through FIFO.
module spi_flash_reader #(
  parameter int MAX_BYTES_PER_CS = 16,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_start,
  input  logic [23:0]                           i_addr,
  input  logic [$clog2(MAX_BYTES_PER_CS+1)-1:0] i_len,
  output logic                                  o_busy,
  output logic                                  o_done,
  output logic                                  o_err,
  output logic [$clog2(MAX_BYTES_PER_CS+1)-1:0] o_TX_Count,
  output logic [7:0]                            o_TX_Byte,
  output logic                                  o_TX_DV,
  input  logic                                  i_TX_Ready,
  input  logic                                  i_RX_DV,
  input  logic [7:0]                            i_RX_Byte,
  input  logic                                  i_done,
  output logic [7:0]                            o_data,
  output logic                                  o_valid,
  input  logic                                  i_ready
);

  localparam int LEN_W = $clog2(MAX_BYTES_PER_CS + 1);
  localparam int TOT_W = LEN_W + 3;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

`ifdef SPI_FLASH_READER_FAST_READ_EN
  localparam logic [7:0] OPCODE = 8'h0B;
  localparam int         HDR    = 5;
`else
  localparam logic [7:0] OPCODE = 8'h03;
  localparam int         HDR    = 4;
`endif

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [23:0]        addr_q;
  logic [LEN_W-1:0]   total_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   tx_cnt;
  logic [LEN_W-1:0]   rx_cnt;
  logic               tx_dv;
  logic [7:0]         tx_byte;
  logic               done;
  logic               err;
  logic               busy;

  logic [TOT_W-1:0]   total_calc;
  logic [CNT_W-1:0]   fifo_free;
  logic               req_bad;
  logic               accept;
  logic               reject;
  logic               tx_fire;
  logic               tx_last;
  logic               rx_take;
  logic               finish;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;
  logic               push;
  logic               pop;

  // Header bytes come from the latched address; everything past the header is a 0x00 clock-out byte.
  function automatic logic [7:0] tx_byte_at(input logic [LEN_W-1:0] idx, input logic [23:0] a);
    logic [7:0] b;
    b = 8'h00;
    case (int'(idx))
      0:       b = OPCODE;
      1:       b = a[23:16];
      2:       b = a[15:8];
      3:       b = a[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign total_calc = TOT_W'(HDR) + TOT_W'(i_len);
  assign fifo_free  = CNT_W'(FIFO_DEPTH) - fifo_cnt;
  assign req_bad    = (i_len == '0) || (int'(total_calc) > MAX_BYTES_PER_CS) ||
                      (int'(fifo_free) < int'(i_len));
  assign accept     = (state == IDLE) && i_start && !req_bad;
  assign reject     = (state == IDLE) && i_start && req_bad;

  // TX_DV is only raised from a low cycle, which guarantees the idle gap between bytes.
  assign tx_fire = (state == SEND) && !tx_dv && i_TX_Ready && (tx_cnt < total_q);
  assign tx_last = (state == SEND) && tx_dv && (tx_cnt == total_q);

  // The rx count gates completion, so a stale i_done level cannot end a new transaction early.
  assign rx_take = i_RX_DV && (state != IDLE) && (rx_cnt < total_q);
  assign finish  = (state == WAIT_DONE) && i_done && (rx_cnt == total_q);

  assign push = rx_take && (int'(rx_cnt) >= HDR) && (int'(rx_cnt) < HDR + int'(len_q)) &&
                (int'(fifo_cnt) != FIFO_DEPTH);
  assign pop  = o_valid && i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = SEND;
      end
      SEND: begin
        busy = 1'b1;
        if (tx_last) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        busy = 1'b1;
        if (finish) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      total_q <= '0;
      len_q   <= '0;
      tx_cnt  <= '0;
      rx_cnt  <= '0;
      tx_dv   <= 1'b0;
      tx_byte <= 8'h00;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done  <= finish;
      err   <= reject;
      tx_dv <= tx_fire;
      if (accept) begin
        addr_q  <= i_addr;
        total_q <= total_calc[LEN_W-1:0];
        len_q   <= i_len;
        tx_cnt  <= '0;
        rx_cnt  <= '0;
      end else begin
        if (tx_fire) begin
          tx_byte <= tx_byte_at(tx_cnt, addr_q);
          tx_cnt  <= tx_cnt + LEN_W'(1);
        end
        if (rx_take) rx_cnt <= rx_cnt + LEN_W'(1);
      end
    end
  end

  // Receive FIFO: pointers wrap naturally since FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_RX_Byte;
  end

  assign o_busy     = busy;
  assign o_done     = done;
  assign o_err      = err;
  assign o_TX_DV    = tx_dv;
  assign o_TX_Byte  = tx_byte;
  assign o_TX_Count = total_q;
  assign o_valid    = (fifo_cnt != '0);
  assign o_data     = o_valid ? mem[rd_ptr] : 8'h00;

endmodule
